// File: rtl/lcd_pkg.sv
// Shared constants, bank-state encoding and address helper for the LCD line buffer.
// Two banks of one display line each sit back to back in a single RAM.
package lcd_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int WORDS_PER_LINE  = 40;
    localparam int LINES_PER_FRAME = 1280;
    localparam int LINE_CLOCKS     = 44;

    localparam int PTR_W     = 6;
    localparam int CNT_W     = 11;
    localparam int ADDR_W    = 7;
    localparam int RAM_DEPTH = 2 * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_e;

    // Bank 1 starts right after the last word of bank 0.
    function automatic logic [ADDR_W-1:0] bank_addr(input logic bank, input logic [PTR_W-1:0] ptr);
        logic [ADDR_W-1:0] base;
        base      = bank ? ADDR_W'(WORDS_PER_LINE) : {ADDR_W{1'b0}};
        bank_addr = base + ADDR_W'(ptr);
    endfunction

endpackage

// File: rtl/lcd_bank_ram.sv
// Simple dual-port RAM holding both line banks; registered read port.
// Contents and read register carry no reset so the array maps onto block RAM.
module lcd_bank_ram
    import lcd_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:RAM_DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Write port and registered read port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lcd_line_buffer.sv
// Ping-pong line buffer between a jittery pixel producer and the LCD timing generator.
// Serves exactly one line per line-start strobe, blanking the line when no full bank is ready.
module lcd_line_buffer
    import lcd_pkg::*;
(
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_wrValid,
    input  logic [DATA_WIDTH-1:0] i_wrData,
    output logic                  o_wrReady,
    input  logic                  i_frameStart,
    input  logic                  i_lineStart,
    input  logic                  i_rdEnable,
    output logic [DATA_WIDTH-1:0] o_rdData,
    output logic                  o_lineActive,
    output logic [CNT_W-1:0]      o_lineCount,
    output logic                  o_underflow,
    output logic                  o_lineShort,
    input  logic                  i_clearFlags
);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(WORDS_PER_LINE - 1);
    localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(LINES_PER_FRAME - 1);

    bank_state_e           bank_q [2];
    bank_state_e           bank_d [2];
    logic                  wr_bank_q, wr_bank_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  line_active_q, line_active_d;
    logic [CNT_W-1:0]      line_count_q, line_count_d;
    logic                  first_line_q, first_line_d;
    logic                  underflow_q, underflow_d;
    logic                  line_short_q, line_short_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  rd_sel_q, rd_sel_d;

    logic                  wr_fire_s;
    logic                  rd_fire_s;
    logic                  rd_last_s;
    logic                  other_bank_s;
    logic                  uf_set_s;
    logic                  short_set_s;
    logic [ADDR_W-1:0]     wr_addr_s;
    logic [ADDR_W-1:0]     rd_addr_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;

    assign wr_fire_s    = i_wrValid & wr_ready_q;
    assign rd_fire_s    = i_rdEnable & line_active_q;
    assign rd_last_s    = rd_fire_s & (rd_ptr_q == LAST_PTR);
    assign other_bank_s = ~rd_bank_q;
    assign wr_addr_s    = bank_addr(wr_bank_q, wr_ptr_q);
    assign rd_addr_s    = bank_addr(rd_bank_q, rd_ptr_q);

    lcd_bank_ram u_ram (
        .clk_i     (i_clock),
        .wr_en_i   (wr_fire_s),
        .wr_addr_i (wr_addr_s),
        .wr_data_i (i_wrData),
        .rd_en_i   (rd_fire_s),
        .rd_addr_i (rd_addr_s),
        .rd_data_o (ram_rdata_s)
    );

    // Bank ownership: producer fills, line start claims, last read or early start frees.
    always_comb begin
        bank_d[0]     = bank_q[0];
        bank_d[1]     = bank_q[1];
        wr_bank_d     = wr_bank_q;
        wr_ptr_d      = wr_ptr_q;
        rd_bank_d     = rd_bank_q;
        rd_ptr_d      = rd_ptr_q;
        line_active_d = line_active_q;
        uf_set_s      = 1'b0;
        short_set_s   = 1'b0;

        if (wr_fire_s) begin
            if (wr_ptr_q == LAST_PTR) begin
                bank_d[wr_bank_q] = BANK_FULL;
                wr_ptr_d          = {PTR_W{1'b0}};
                wr_bank_d         = ~wr_bank_q;
            end else begin
                bank_d[wr_bank_q] = BANK_FILLING;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_last_s) begin
            bank_d[rd_bank_q] = BANK_EMPTY;
            rd_ptr_d          = {PTR_W{1'b0}};
            line_active_d     = 1'b0;
        end else if (rd_fire_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // A line that coincides with its own final read is complete, not short.
        if (i_lineStart) begin
            if (line_active_q) begin
                bank_d[rd_bank_q] = BANK_EMPTY;
                short_set_s       = ~rd_last_s;
            end else begin
                short_set_s = 1'b0;
            end
            if (bank_q[other_bank_s] == BANK_FULL) begin
                bank_d[other_bank_s] = BANK_READING;
                rd_bank_d            = other_bank_s;
                rd_ptr_d             = {PTR_W{1'b0}};
                line_active_d        = 1'b1;
            end else begin
                line_active_d = 1'b0;
                uf_set_s      = 1'b1;
            end
        end else begin
            rd_bank_d = rd_bank_q;
        end

        wr_ready_d = (bank_d[wr_bank_d] == BANK_EMPTY) || (bank_d[wr_bank_d] == BANK_FILLING);

        if (i_rdEnable) begin
            rd_sel_d = line_active_q;
        end else begin
            rd_sel_d = rd_sel_q;
        end
    end

    // Line counter and sticky flags; a new flag event overrides a concurrent clear.
    always_comb begin
        line_count_d = line_count_q;
        first_line_d = first_line_q;
        if (i_frameStart) begin
            line_count_d = {CNT_W{1'b0}};
            first_line_d = ~i_lineStart;
        end else if (i_lineStart) begin
            if (first_line_q) begin
                first_line_d = 1'b0;
            end else if (line_count_q == LAST_LINE) begin
                line_count_d = {CNT_W{1'b0}};
            end else begin
                line_count_d = line_count_q + CNT_W'(1);
            end
        end else begin
            first_line_d = first_line_q;
        end
        underflow_d  = uf_set_s | (underflow_q & ~i_clearFlags);
        line_short_d = short_set_s | (line_short_q & ~i_clearFlags);
    end

    // State registers; reset drops buffered words and points the reader at bank 1.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            bank_q[0]     <= BANK_EMPTY;
            bank_q[1]     <= BANK_EMPTY;
            wr_bank_q     <= 1'b0;
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_bank_q     <= 1'b1;
            rd_ptr_q      <= {PTR_W{1'b0}};
            line_active_q <= 1'b0;
            line_count_q  <= {CNT_W{1'b0}};
            first_line_q  <= 1'b1;
            underflow_q   <= 1'b0;
            line_short_q  <= 1'b0;
            wr_ready_q    <= 1'b0;
            rd_sel_q      <= 1'b0;
        end else begin
            bank_q[0]     <= bank_d[0];
            bank_q[1]     <= bank_d[1];
            wr_bank_q     <= wr_bank_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_bank_q     <= rd_bank_d;
            rd_ptr_q      <= rd_ptr_d;
            line_active_q <= line_active_d;
            line_count_q  <= line_count_d;
            first_line_q  <= first_line_d;
            underflow_q   <= underflow_d;
            line_short_q  <= line_short_d;
            wr_ready_q    <= wr_ready_d;
            rd_sel_q      <= rd_sel_d;
        end
    end

    assign o_wrReady    = wr_ready_q;
    assign o_rdData     = rd_sel_q ? ram_rdata_s : {DATA_WIDTH{1'b0}};
    assign o_lineActive = line_active_q;
    assign o_lineCount  = line_count_q;
    assign o_underflow  = underflow_q;
    assign o_lineShort  = line_short_q;

endmodule
